// File: rtl/barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : barrel_normalizer
// Brief    : Valid/ready normalizer; binary-searches the shift that moves the
//            leading set bit to the MSB, one search step per clock.
//            Optional macro BARREL_NORM_RIGHT_EN adds norm_dir (trailing zeros).
// Revision : 1.0 - initial release
// ============================================================================
module barrel_normalizer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in,
`ifdef BARREL_NORM_RIGHT_EN
    input  logic                     norm_dir,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(WIDTH)-1:0] shift_amt,
    output logic                     zero
);

    localparam int LOG2 = $clog2(WIDTH);

    localparam logic [LOG2-1:0]  c_half   = LOG2'(WIDTH / 2);
    localparam logic [LOG2-1:0]  c_last_k = LOG2'(LOG2 - 1);
    localparam logic [LOG2-1:0]  c_k_one  = LOG2'(1);
    localparam logic [WIDTH-1:0] c_ones   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_w;
    logic [LOG2-1:0]  r_c;
    logic [LOG2-1:0]  r_k;
    logic             r_zero;

    logic [LOG2-1:0]  w_step;
    logic [WIDTH-1:0] w_hi_mask;
    logic             w_hit;
    logic [WIDTH-1:0] w_shifted;

`ifdef BARREL_NORM_RIGHT_EN
    logic             r_dir;
    logic [WIDTH-1:0] w_lo_mask;
`endif

    // Step size halves each cycle: WIDTH/2, WIDTH/4, ..., 1.
    always_comb begin
        w_step    = c_half >> r_k;
        w_hi_mask = ~(c_ones >> w_step);
`ifdef BARREL_NORM_RIGHT_EN
        w_lo_mask = ~(c_ones << w_step);
        if (r_dir) begin
            w_hit     = ((r_w & w_lo_mask) == '0);
            w_shifted = r_w >> w_step;
        end else begin
            w_hit     = ((r_w & w_hi_mask) == '0);
            w_shifted = r_w << w_step;
        end
`else
        w_hit     = ((r_w & w_hi_mask) == '0);
        w_shifted = r_w << w_step;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)        w_next_state = S_BUSY;
            S_BUSY:  if (r_k == c_last_k) w_next_state = S_DONE;
            S_DONE:  if (out_ready)       w_next_state = S_IDLE;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_c    <= '0;
            r_k    <= '0;
            r_zero <= 1'b0;
`ifdef BARREL_NORM_RIGHT_EN
            r_dir  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_w    <= data_in;
                        r_c    <= '0;
                        r_k    <= '0;
                        r_zero <= (data_in == '0);
`ifdef BARREL_NORM_RIGHT_EN
                        r_dir  <= norm_dir;
`endif
                    end
                end
                S_BUSY: begin
                    // The step sizes sum to WIDTH-1, so r_c cannot wrap.
                    if (w_hit) begin
                        r_w <= w_shifted;
                        r_c <= r_c + w_step;
                    end
                    r_k <= r_k + c_k_one;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign data_out  = r_w;
    assign shift_amt = r_c;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_normalizer
// Brief    : Scoreboard bench for barrel_normalizer (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_normalizer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       z;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       norm_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic [2:0] shift_amt;
    logic       zero;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    barrel_normalizer #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
`ifdef BARREL_NORM_RIGHT_EN
        .norm_dir  (norm_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .shift_amt (shift_amt),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: linear scan, independent of the binary search in the design.
    function automatic exp_t model(input logic [7:0] d, input logic dir);
        exp_t       r;
        logic [7:0] w;
        int         cnt;
        w   = d;
        cnt = 0;
        r.z = (d == 8'h00);
        if (r.z) begin
            r.d = 8'h00;
            r.s = 3'd7;
        end else begin
            if (dir) begin
                while (!w[0]) begin w = w >> 1; cnt++; end
            end else begin
                while (!w[7]) begin w = w << 1; cnt++; end
            end
            r.d = w;
            r.s = 3'(cnt);
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic dir);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check_val("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        data_in  = d;
        norm_dir = dir;
        sb.push_back(model(d, dir));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        check_val("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_data"},  {24'd0, data_out},  {24'd0, e.d});
            check_val({tag, "_shift"}, {29'd0, shift_amt}, {29'd0, e.s});
            check_val({tag, "_zero"},  {31'd0, zero},      {31'd0, e.z});
        end
    endtask

    task automatic run_one(input string tag, input logic [7:0] d, input logic dir);
        int cyc;
        send(d, dir);
        wait_valid(cyc);
        compare_out(tag);
        @(posedge clk);
        #1;
        check_val({tag, "_released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 8'h00;
        norm_dir  = 1'b0;
        out_ready = 1'b1;

        #12;
        check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_data_out",  {24'd0, data_out},  32'd0);
        check_val("rst_shift",     {29'd0, shift_amt}, 32'd0);
        check_val("rst_zero",      {31'd0, zero},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and turnaround on 0x10.
        send(8'h10, 1'b0);
        wait_valid(cyc);
        check_val("latency", 32'(cyc), 32'd3);
        check_val("lat_in_ready_low", {31'd0, in_ready}, 32'd0);
        compare_out("x10");
        @(posedge clk);
        #1;
        check_val("turn_in_ready", {31'd0, in_ready},  32'd1);
        check_val("turn_out_low",  {31'd0, out_valid}, 32'd0);

        run_one("x01", 8'h01, 1'b0);
        run_one("x80", 8'h80, 1'b0);
        run_one("x5A", 8'h5A, 1'b0);
        run_one("x00", 8'h00, 1'b0);
        run_one("xFF", 8'hFF, 1'b0);

        // Backpressure: result held, in_ready low, extra input ignored.
        out_ready = 1'b0;
        send(8'h03, 1'b0);
        wait_valid(cyc);
        compare_out("stall");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_in  = 8'hFF;
            @(posedge clk);
            #1;
            check_val("stall_valid",    {31'd0, out_valid}, 32'd1);
            check_val("stall_data",     {24'd0, data_out},  32'h0C0);
            check_val("stall_shift",    {29'd0, shift_amt}, 32'd6);
            check_val("stall_in_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("stall_done_valid", {31'd0, out_valid}, 32'd0);
        check_val("stall_done_ready", {31'd0, in_ready},  32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("stall_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset during BUSY drops the transaction.
        send(8'h01, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
        check_val("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_data",     {24'd0, data_out},  32'd0);
        check_val("mid_rst_shift",    {29'd0, shift_amt}, 32'd0);
        check_val("mid_rst_zero",     {31'd0, zero},      32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_one("x20", 8'h20, 1'b0);

`ifdef BARREL_NORM_RIGHT_EN
        run_one("r08", 8'h08, 1'b1);
        run_one("r00", 8'h00, 1'b1);
        run_one("r5A", 8'h5A, 1'b1);
        run_one("l08", 8'h08, 1'b0);
`endif

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
